// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the TPU GEMM control slice.
//   - Buffer geometry: BUF_DEPTH rows, ADDR_W address bits, DIM_W dimension
//     field width, WORD_SIZE bits per global-buffer word.
//   - state_e: main sequencer FSM encoding.
//   - tile_cycles(): cycles spent per output tile (clear + feed + flush + WB).
// ---------------------------------------------------------------------------
package tpu_pkg;

    localparam int ADDR_W    = 5;
    localparam int BUF_DEPTH = 32;
    localparam int DIM_W     = 5;
    localparam int WORD_SIZE = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CLR   = 3'd2,
        FEED  = 3'd3,
        FLUSH = 3'd4,
        WB    = 3'd5,
        OUT   = 3'd6
    } state_e;

    // One clear cycle, K feed cycles, 2S-2 flush cycles and S write-back cycles.
    function automatic int tile_cycles(input int k_dim, input int s_dim);
        return k_dim + 3 * s_dim - 1;
    endfunction

endpackage

// File: rtl/tpu_tile_iter.sv
// ---------------------------------------------------------------------------
// tpu_tile_iter
// Walks the output tiles of an M x N result, tn inner and tm outer, starting
// at (0,0). Tile origins are kept directly as lane offsets (tm*S, tn*S).
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   clr             return to tile (0,0)
//   adv             step to the next tile (ignored on the last tile)
//   m_dim, n_dim    captured dimensions minus one
//   tile_row        tm*S, lane offset into the A word
//   tile_col        tn*S, lane offset into the B word
//   last_tile       current tile is the final one of the job
// ---------------------------------------------------------------------------
module tpu_tile_iter
    import tpu_pkg::*;
#(
    parameter int ARRAY_SIZE = 8,
    parameter int ADDR_W     = tpu_pkg::ADDR_W,
    parameter int DIM_W      = tpu_pkg::DIM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    input  logic [DIM_W-1:0]  m_dim,
    input  logic [DIM_W-1:0]  n_dim,
    output logic [ADDR_W-1:0] tile_row,
    output logic [ADDR_W-1:0] tile_col,
    output logic              last_tile
);

    // One extra bit so origin + S never overflows before the compare.
    localparam int                SUM_W = ADDR_W + 1;
    localparam logic [SUM_W-1:0]  STEP  = SUM_W'(ARRAY_SIZE);

    logic tm_last_s;
    logic tn_last_s;

    // A tile is the last along an axis when the next origin lies past the dimension.
    always_comb begin
        tm_last_s = (({1'b0, tile_row} + STEP) > SUM_W'(m_dim));
        tn_last_s = (({1'b0, tile_col} + STEP) > SUM_W'(n_dim));
        last_tile = tm_last_s && tn_last_s;
    end

    // Tile origin registers: tn wraps into the next tm row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_row <= '0;
            tile_col <= '0;
        end else if (clr) begin
            tile_row <= '0;
            tile_col <= '0;
        end else if (adv && !(tm_last_s && tn_last_s)) begin
            if (tn_last_s) begin
                tile_col <= '0;
                tile_row <= tile_row + ADDR_W'(ARRAY_SIZE);
            end else begin
                tile_col <= tile_col + ADDR_W'(ARRAY_SIZE);
                tile_row <= tile_row;
            end
        end else begin
            tile_row <= tile_row;
            tile_col <= tile_col;
        end
    end

endmodule

// File: rtl/tpu_gemm_ctrl.sv
// ---------------------------------------------------------------------------
// tpu_gemm_ctrl
// Top-level GEMM sequencer: captures the 32-row A/B load and m/n/k, then per
// output tile clears, feeds, flushes and writes back the systolic array, and
// finally streams the 32-row output buffer. Control only, no data.
// All outputs are registered; each reflects the state the FSM is in during
// that cycle (load writes therefore trail the accepted in_valid by one cycle).
// Ports:
//   clk, rst_n                  clock / asynchronous active-low reset
//   in_valid, m, n, k           load handshake and dimensions (minus one)
//   gbuff_wr_en/_addr           A/B row write during load
//   gbuff_rd_en/_addr           inner-index read during FEED
//   tile_row, tile_col          current tile lane offsets
//   pe_clear, pe_flush          array accumulator clear / zero-feed drain
//   ob_wr_en/_addr/_row         result row write-back
//   ob_rd_en/_addr, out_valid   output buffer streaming
//   busy                        high outside IDLE
// Optional build macro TPU_GEMM_CTRL_PERF_EN adds perf_cycles / perf_tiles.
// ---------------------------------------------------------------------------
module tpu_gemm_ctrl
    import tpu_pkg::*;
#(
    parameter int ARRAY_SIZE = 8,
    parameter int ADDR_W     = tpu_pkg::ADDR_W,
    parameter int BUF_DEPTH  = tpu_pkg::BUF_DEPTH,
    parameter int DIM_W      = tpu_pkg::DIM_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [DIM_W-1:0]              m,
    input  logic [DIM_W-1:0]              n,
    input  logic [DIM_W-1:0]              k,
    output logic                          gbuff_wr_en,
    output logic [ADDR_W-1:0]             gbuff_wr_addr,
    output logic                          gbuff_rd_en,
    output logic [ADDR_W-1:0]             gbuff_rd_addr,
    output logic [ADDR_W-1:0]             tile_row,
    output logic [ADDR_W-1:0]             tile_col,
    output logic                          pe_clear,
    output logic                          pe_flush,
    output logic                          ob_wr_en,
    output logic [ADDR_W-1:0]             ob_wr_addr,
    output logic [$clog2(ARRAY_SIZE)-1:0] ob_wr_row,
    output logic                          ob_rd_en,
    output logic [ADDR_W-1:0]             ob_rd_addr,
    output logic                          out_valid,
    output logic                          busy
`ifdef TPU_GEMM_CTRL_PERF_EN
    ,
    output logic [31:0]                   perf_cycles,
    output logic [9:0]                    perf_tiles
`endif
);

    localparam int               LOG2S      = $clog2(ARRAY_SIZE);
    localparam int               CNT_W      = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(2 * ARRAY_SIZE - 3);
    localparam logic [CNT_W-1:0] WB_LAST    = CNT_W'(ARRAY_SIZE - 1);

    state_e             state_r;
    state_e             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic [DIM_W-1:0]   m_r, n_r, k_r;
    logic [DIM_W-1:0]   m_s, n_s, k_s;
    logic [CNT_W-1:0]   row_sum_s;
    logic               last_tile_s;
    logic               iter_clr_s;
    logic               iter_adv_s;

    logic               wr_en_s;
    logic [ADDR_W-1:0]  wr_addr_s;
    logic               rd_en_s;
    logic [ADDR_W-1:0]  rd_addr_s;
    logic               clear_s;
    logic               flush_s;
    logic               ob_wr_en_s;
    logic [ADDR_W-1:0]  ob_wr_addr_s;
    logic [LOG2S-1:0]   ob_wr_row_s;
    logic               ob_rd_en_s;
    logic [ADDR_W-1:0]  ob_rd_addr_s;
    logic               out_valid_s;
    logic               busy_s;

    tpu_tile_iter #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .ADDR_W     (ADDR_W),
        .DIM_W      (DIM_W)
    ) u_tile_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (iter_clr_s),
        .adv       (iter_adv_s),
        .m_dim     (m_r),
        .n_dim     (n_r),
        .tile_row  (tile_row),
        .tile_col  (tile_col),
        .last_tile (last_tile_s)
    );

    // Next-state, phase counter and next-cycle output decode.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        m_s       = m_r;
        n_s       = n_r;
        k_s       = k_r;
        wr_en_s   = 1'b0;
        wr_addr_s = '0;

        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s   = LOAD;
                    m_s       = m;
                    n_s       = n;
                    k_s       = k;
                    cnt_s     = CNT_W'(1);
                    wr_en_s   = 1'b1;
                    wr_addr_s = '0;
                end else begin
                    cnt_s = '0;
                end
            end
            LOAD: begin
                // cnt_r holds the number of rows accepted so far.
                wr_addr_s = gbuff_wr_addr;
                if (cnt_r == DEPTH_CNT) begin
                    state_s = CLR;
                    cnt_s   = '0;
                end else if (in_valid) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = ADDR_W'(cnt_r);
                    cnt_s     = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            CLR: begin
                state_s = FEED;
                cnt_s   = '0;
            end
            FEED: begin
                if (cnt_r == CNT_W'(k_r)) begin
                    state_s = FLUSH;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            FLUSH: begin
                if (cnt_r == FLUSH_LAST) begin
                    state_s = WB;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            WB: begin
                if (cnt_r == WB_LAST) begin
                    state_s = last_tile_s ? OUT : CLR;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            OUT: begin
                // One extra cycle after the last read lets out_valid drain.
                if (cnt_r == DEPTH_CNT) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase

        iter_clr_s = (state_s == IDLE);
        iter_adv_s = (state_r == WB) && (cnt_r == WB_LAST) && !last_tile_s;

        // Tile origin is stable whenever the next state is WB.
        row_sum_s    = CNT_W'(tile_row) + cnt_s;
        rd_en_s      = (state_s == FEED);
        rd_addr_s    = rd_en_s ? ADDR_W'(cnt_s) : '0;
        clear_s      = (state_s == CLR);
        flush_s      = (state_s == FLUSH);
        ob_wr_en_s   = (state_s == WB) && (row_sum_s <= CNT_W'(m_r));
        ob_wr_addr_s = (state_s == WB) ? row_sum_s[ADDR_W-1:0] : '0;
        ob_wr_row_s  = (state_s == WB) ? cnt_s[LOG2S-1:0] : '0;
        ob_rd_en_s   = (state_s == OUT) && (cnt_s < DEPTH_CNT);
        ob_rd_addr_s = ob_rd_en_s ? ADDR_W'(cnt_s) : '0;
        out_valid_s  = ob_rd_en;
        busy_s       = (state_s != IDLE);
    end

    // State, counter and captured dimension registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            m_r     <= '0;
            n_r     <= '0;
            k_r     <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            m_r     <= m_s;
            n_r     <= n_s;
            k_r     <= k_s;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gbuff_wr_en   <= 1'b0;
            gbuff_wr_addr <= '0;
            gbuff_rd_en   <= 1'b0;
            gbuff_rd_addr <= '0;
            pe_clear      <= 1'b0;
            pe_flush      <= 1'b0;
            ob_wr_en      <= 1'b0;
            ob_wr_addr    <= '0;
            ob_wr_row     <= '0;
            ob_rd_en      <= 1'b0;
            ob_rd_addr    <= '0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            gbuff_wr_en   <= wr_en_s;
            gbuff_wr_addr <= wr_addr_s;
            gbuff_rd_en   <= rd_en_s;
            gbuff_rd_addr <= rd_addr_s;
            pe_clear      <= clear_s;
            pe_flush      <= flush_s;
            ob_wr_en      <= ob_wr_en_s;
            ob_wr_addr    <= ob_wr_addr_s;
            ob_wr_row     <= ob_wr_row_s;
            ob_rd_en      <= ob_rd_en_s;
            ob_rd_addr    <= ob_rd_addr_s;
            out_valid     <= out_valid_s;
            busy          <= busy_s;
        end
    end

`ifdef TPU_GEMM_CTRL_PERF_EN
    // Busy-cycle and completed-tile counters; both hold while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= 32'd0;
            perf_tiles  <= 10'd0;
        end else begin
            if ((state_r == IDLE) && (state_s == LOAD)) begin
                perf_cycles <= 32'd0;
            end else if (state_r != IDLE) begin
                perf_cycles <= perf_cycles + 32'd1;
            end else begin
                perf_cycles <= perf_cycles;
            end
            if ((state_r == WB) && (state_s != WB)) begin
                perf_tiles <= perf_tiles + 10'd1;
            end else begin
                perf_tiles <= perf_tiles;
            end
        end
    end
`endif

endmodule

// File: doc/tpu_gemm_ctrl.md
Name: tpu_gemm_ctrl

Overview:
- Top-level sequencer for the TPU GEMM datapath.
- Captures the 32-row A/B global-buffer load and the m/n/k dimensions.
- Tiles the M×N output into ARRAY_SIZE×ARRAY_SIZE blocks, drives the systolic array through clear/feed/flush/write-back per tile, then streams the 32-row output buffer with out_valid.
- Sits between the top-level handshake and the gbuff/PE-array/output-buffer datapath. Issues control only; carries no data.

Parameters:
- ARRAY_SIZE, 8, systolic array dimension S (power of 2, 2..32).
- ADDR_W, 5, global/output buffer address width.
- BUF_DEPTH, 32, rows per buffer (= 2^ADDR_W).
- DIM_W, 5, width of the m/n/k fields.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  load word valid (A and B rows presented together).
- m  in  DIM_W  rows of A minus 1. Sampled with the first in_valid of a job.
- n  in  DIM_W  cols of B minus 1. Sampled likewise.
- k  in  DIM_W  inner dimension minus 1. Sampled likewise.
- gbuff_wr_en  out  1  write A/B gbuff row.
- gbuff_wr_addr  out  ADDR_W  load row index.
- gbuff_rd_en  out  1  read A column / B row for the array feed.
- gbuff_rd_addr  out  ADDR_W  inner index kk.
- tile_row  out  ADDR_W  tm*S, lane offset into A word.
- tile_col  out  ADDR_W  tn*S, lane offset into B word.
- pe_clear  out  1  zero PE accumulators.
- pe_flush  out  1  array fed zeros (skew drain).
- ob_wr_en  out  1  write one array result row to the output buffer.
- ob_wr_addr  out  ADDR_W  tile_row + r.
- ob_wr_row  out  log2(S)  array row r being written.
- ob_rd_en  out  1  output buffer read.
- ob_rd_addr  out  ADDR_W  output row index.
- out_valid  out  1  gbuff_out row valid.
- busy  out  1  high outside IDLE.

Behaviour:
- Reset: asynchronous; all outputs and counters go to 0; FSM goes to IDLE. Reset mid-job aborts the job with no residual outputs.
- Dimensions: M=m+1, N=n+1, K=k+1 (range 1..32). TM=ceil(M/S), TN=ceil(N/S).
- FSM states: IDLE → LOAD → CLR → FEED → FLUSH → WB → (next tile: CLR | last tile: OUT) → IDLE.
- IDLE:
  - in_valid=1: latch m/n/k, assert gbuff_wr_en with addr 0, go to LOAD.
- LOAD:
  - gbuff_wr_en = in_valid; addr increments per accepted word.
  - in_valid gaps are allowed; addr holds during gaps.
  - After the BUF_DEPTH-th word (addr 31 written), go to CLR next cycle.
- Tile order: tn inner, tm outer, starting at (0,0).
- CLR: 1 cycle, pe_clear=1.
- FEED: K cycles.
  - gbuff_rd_en=1, gbuff_rd_addr = kk = 0..K-1.
  - tile_row/tile_col held for the whole tile.
- FLUSH: 2S-2 cycles, pe_flush=1, gbuff_rd_en=0.
- WB: S cycles.
  - ob_wr_en=1 only when tile_row+r < M; rows beyond M are suppressed.
  - ob_wr_row = r, ob_wr_addr = tile_row + r.
- Cycles per tile: K+3S-1.
- OUT: BUF_DEPTH cycles.
  - ob_rd_en=1, ob_rd_addr = 0..31.
  - out_valid follows ob_rd_en with exactly 1-cycle latency, for 32 consecutive cycles.
  - Rows ≥ M read whatever the output buffer holds; the output buffer is cleared by the datapath on load, not here.
- Completion: the cycle after the last out_valid, go to IDLE and drop busy.
- in_valid outside IDLE/LOAD is ignored; m/n/k changes after capture are ignored.
- Counter wrap: address counters are ADDR_W wide and never wrap within a phase. A 32×32×32 job gives TM=TN=4 at S=8, 16 tiles.

Optional Feature:
- Macro TPU_GEMM_CTRL_PERF_EN.
- Defined: adds outputs perf_cycles[31:0] and perf_tiles[9:0].
  - perf_cycles counts cycles with busy=1, cleared on IDLE→LOAD.
  - perf_tiles increments on each WB→CLR/OUT transition.
  - Both hold their value in IDLE; both reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package tpu_pkg:
  - FSM state enum (IDLE, LOAD, CLR, FEED, FLUSH, WB, OUT).
  - BUF_DEPTH, ADDR_W, DIM_W, WORD_SIZE=256.
  - Tile-cycle constant function K+3S-1.
- One natural sub-module tpu_tile_iter: tm/tn loop counters with last-tile flags and tile_row/tile_col generation. Main FSM and phase counters stay in tpu_gemm_ctrl.

Test Plan:
- M=N=K=8 (m=n=k=7), S=8, 32 back-to-back in_valid:
  - CLR at cycle C after the last load word.
  - gbuff_rd_addr 0..7 on C+1..C+8; pe_flush C+9..C+22.
  - ob_wr_addr 0..7 on C+23..C+30; ob_rd_en from C+31; out_valid C+32..C+63.
  - busy=0 at C+64.
- m=n=k=31, S=8: 16 tiles in tn-inner order, tile_col sequence 0,8,16,24 per tm. First out_valid 16*55+1 cycles after first CLR.
- M=5 (m=4), N=K=8: exactly 5 ob_wr_en pulses (rows 0..4) per tile.
- Load with in_valid deasserted every other cycle: gbuff_wr_addr advances only on valid; CLR begins after the 32nd valid word.
- Pulse rst_n low mid-FEED: all outputs 0 immediately (asynchronous, no clock edge needed); FSM in IDLE; a new full job then completes correctly.
- With TPU_GEMM_CTRL_PERF_EN defined, run the 8×8×8 job: perf_tiles=1, perf_cycles = 32 (load) + 31 (tile) + 33 (output) = 96.
